// File: rtl/multiplexor_display_7seg.sv
// Four-digit BCD latch and time-multiplexed driver for a common-anode 7-segment display.
// Includes a programmable scan rate, optional leading-zero blanking and a dash for codes above 9.
module multiplexor_display_7seg #(
   parameter int CUENTA_REFRESCO   = 50000,
   parameter bit ANODO_ACTIVO_BAJO = 1'b1,
   parameter bit SEG_ACTIVO_BAJO   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cargar,
   input  logic [3:0] Millares,
   input  logic [3:0] Centenas,
   input  logic [3:0] Decenas,
   input  logic [3:0] Unidades,
   input  logic       blanqueo_ceros,
   output logic [3:0] anodos,
   output logic [6:0] segmentos,
   output logic       fin_barrido
);

   localparam int            CW         = (CUENTA_REFRESCO > 1) ? $clog2(CUENTA_REFRESCO) : 1;
   localparam logic [CW-1:0] CNT_MAX    = CW'(CUENTA_REFRESCO - 1);
   localparam logic [3:0]    ANODOS_OFF = ANODO_ACTIVO_BAJO ? 4'b1111 : 4'b0000;
   localparam logic [6:0]    SEG_OFF    = SEG_ACTIVO_BAJO ? 7'b1111111 : 7'b0000000;

   // Active-high pattern {a,b,c,d,e,f,g}; anything that is not a decimal digit becomes a dash.
   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1111110;
         4'd1:    p = 7'b0110000;
         4'd2:    p = 7'b1101101;
         4'd3:    p = 7'b1111001;
         4'd4:    p = 7'b0110011;
         4'd5:    p = 7'b1011011;
         4'd6:    p = 7'b1011111;
         4'd7:    p = 7'b1110000;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1111011;
         default: p = 7'b0000001;
      endcase
      return p;
   endfunction

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [3:0]    r_mil, r_cen, r_dec, r_uni;
   logic [3:0]    r_anodos;
   logic [6:0]    r_seg;
   logic          r_fin;

   logic          w_wrap;
   logic [3:0]    w_digito;
   logic          w_blank;
   logic [3:0]    w_onehot;
   logic [3:0]    w_anodos_next;
   logic [6:0]    w_seg_next;

   // Slot selection and leading-zero blanking for the digit currently being scanned.
   always_comb begin
      w_wrap   = (r_cnt == CNT_MAX);
      w_digito = 4'd0;
      w_blank  = 1'b0;
      w_onehot = 4'b0000;
      case (r_idx)
         2'd0: begin
            w_digito = r_uni;
            w_blank  = 1'b0;
            w_onehot = 4'b0001;
         end
         2'd1: begin
            w_digito = r_dec;
            w_blank  = blanqueo_ceros && (r_mil == 4'd0) && (r_cen == 4'd0) && (r_dec == 4'd0);
            w_onehot = 4'b0010;
         end
         2'd2: begin
            w_digito = r_cen;
            w_blank  = blanqueo_ceros && (r_mil == 4'd0) && (r_cen == 4'd0);
            w_onehot = 4'b0100;
         end
         2'd3: begin
            w_digito = r_mil;
            w_blank  = blanqueo_ceros && (r_mil == 4'd0);
            w_onehot = 4'b1000;
         end
         default: begin
            w_digito = 4'd0;
            w_blank  = 1'b1;
            w_onehot = 4'b0000;
         end
      endcase
   end

   // Polarity mapping of the next anode/segment values.
   always_comb begin
      w_anodos_next = ANODOS_OFF;
      w_seg_next    = SEG_OFF;
      if (w_blank) begin
         w_anodos_next = ANODOS_OFF;
         w_seg_next    = SEG_OFF;
      end else begin
         w_anodos_next = ANODO_ACTIVO_BAJO ? ~w_onehot : w_onehot;
         w_seg_next    = SEG_ACTIVO_BAJO ? ~f_decode(w_digito) : f_decode(w_digito);
      end
   end

   // Refresh counter and digit index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
         r_idx <= r_idx;
      end
   end

   // Digit latch, loaded as a group on the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mil <= 4'd0;
         r_cen <= 4'd0;
         r_dec <= 4'd0;
         r_uni <= 4'd0;
      end else if (cargar) begin
         r_mil <= Millares;
         r_cen <= Centenas;
         r_dec <= Decenas;
         r_uni <= Unidades;
      end else begin
         r_mil <= r_mil;
         r_cen <= r_cen;
         r_dec <= r_dec;
         r_uni <= r_uni;
      end
   end

   // Registered display outputs and end-of-scan pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_anodos <= ANODOS_OFF;
         r_seg    <= SEG_OFF;
         r_fin    <= 1'b0;
      end else begin
         r_anodos <= w_anodos_next;
         r_seg    <= w_seg_next;
         r_fin    <= w_wrap && (r_idx == 2'd3);
      end
   end

   assign anodos      = r_anodos;
   assign segmentos   = r_seg;
   assign fin_barrido = r_fin;

endmodule
